// File: rtl/game_round_tracker_if.sv
// Handshake and result bus between the round tracker and the game controller.
// The master side drives requests and grading results; the slave side is the tracker.
interface game_round_tracker_if;
    logic       startGame;
    logic       masterLoaded;
    logic       gradeIt;
    logic [3:0] ZnarlyCount;
    logic [3:0] ZoodCount;
    logic       GameWon;
    logic       loadingShape;
    logic       ongoingGame;
    logic       areRoundsLeft;
    logic       doneGrading;
    logic [3:0] roundsUsed;
    logic [3:0] lastZnarly;
    logic [3:0] lastZood;
    logic       won;
    logic       lost;
    logic [3:0] gamesWon;

    modport master (
        output startGame, masterLoaded, gradeIt, ZnarlyCount, ZoodCount, GameWon,
        input  loadingShape, ongoingGame, areRoundsLeft, doneGrading, roundsUsed,
               lastZnarly, lastZood, won, lost, gamesWon
    );

    modport slave (
        input  startGame, masterLoaded, gradeIt, ZnarlyCount, ZoodCount, GameWon,
        output loadingShape, ongoingGame, areRoundsLeft, doneGrading, roundsUsed,
               lastZnarly, lastZood, won, lost, gamesWon
    );
endinterface

// File: rtl/game_round_tracker.sv
// Round/game sequencer: master load, up to MAX_ROUNDS graded guesses, win/loss
// status and a saturating count of games won. All outputs are registered.
module game_round_tracker #(
    parameter int MAX_ROUNDS = 8
) (
    input logic                  clock,
    input logic                  reset_L,
    game_round_tracker_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        GRADE = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5
    } state_t;

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    state_t     state;
    state_t     nextState;
    logic       enterLoad;
    logic       enterWon;
    logic       gradeExit;
    logic       nextOngoing;
    logic [3:0] nextRounds;

    // Next-state and next round count, decoded once so registered outputs can follow them.
    always_comb begin
        nextState = state;
        gradeExit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.startGame) nextState = LOAD;
                else               nextState = IDLE;
            end
            LOAD: begin
                if (bus.masterLoaded) nextState = PLAY;
                else                  nextState = LOAD;
            end
            PLAY: begin
                if (bus.gradeIt) nextState = GRADE;
                else             nextState = PLAY;
            end
            GRADE: begin
                gradeExit = 1'b1;
                if (bus.GameWon)                              nextState = WON;
                else if ((bus.roundsUsed + 4'd1) == MAX_R)    nextState = LOST;
                else                                          nextState = PLAY;
            end
            WON, LOST: begin
                if (bus.startGame) nextState = LOAD;
                else               nextState = state;
            end
            default: nextState = IDLE;
        endcase

        enterLoad   = (nextState == LOAD) && (state != LOAD);
        enterWon    = (nextState == WON) && (state != WON);
        nextOngoing = (nextState == PLAY) || (nextState == GRADE);

        // The round count can only reach MAX_R on the grade that ends the game.
        if (enterLoad)                              nextRounds = 4'd0;
        else if (gradeExit && (bus.roundsUsed < MAX_R)) nextRounds = bus.roundsUsed + 4'd1;
        else                                        nextRounds = bus.roundsUsed;
    end

    // State register plus all registered outputs; reset discards any pending capture.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state             <= IDLE;
            bus.roundsUsed    <= 4'd0;
            bus.lastZnarly    <= 4'd0;
            bus.lastZood      <= 4'd0;
            bus.gamesWon      <= 4'd0;
            bus.loadingShape  <= 1'b0;
            bus.ongoingGame   <= 1'b0;
            bus.areRoundsLeft <= 1'b0;
            bus.doneGrading   <= 1'b0;
            bus.won           <= 1'b0;
            bus.lost          <= 1'b0;
        end else begin
            state             <= nextState;
            bus.roundsUsed    <= nextRounds;
            bus.doneGrading   <= gradeExit;
            bus.loadingShape  <= (nextState == LOAD);
            bus.ongoingGame   <= nextOngoing;
            bus.areRoundsLeft <= nextOngoing && (nextRounds < MAX_R);
            bus.won           <= (nextState == WON);
            bus.lost          <= (nextState == LOST);

            if (enterLoad) begin
                bus.lastZnarly <= 4'd0;
                bus.lastZood   <= 4'd0;
            end else if (gradeExit) begin
                bus.lastZnarly <= bus.ZnarlyCount;
                bus.lastZood   <= bus.ZoodCount;
            end else begin
                bus.lastZnarly <= bus.lastZnarly;
                bus.lastZood   <= bus.lastZood;
            end

            if (enterWon && (bus.gamesWon != 4'd15)) bus.gamesWon <= bus.gamesWon + 4'd1;
            else                                     bus.gamesWon <= bus.gamesWon;
        end
    end

endmodule

// File: tb/tb_game_round_tracker.sv
// Directed bench for game_round_tracker: grade results go through a scoreboard
// queue and every comparison is an immediate assertion.
module tb_game_round_tracker;

    typedef struct packed {
        logic [3:0] zn;
        logic [3:0] zd;
        logic [3:0] rounds;
    } exp_t;

    logic clock = 1'b0;
    logic reset_L = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   expRounds = 0;
    exp_t sbQ[$];

    game_round_tracker_if bus();

    game_round_tracker #(.MAX_ROUNDS(8)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [21:0] outVec();
        return {bus.loadingShape, bus.ongoingGame, bus.areRoundsLeft, bus.doneGrading,
                bus.won, bus.lost, bus.roundsUsed, bus.lastZnarly, bus.lastZood, bus.gamesWon};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic startPulse();
        bus.startGame = 1'b1;
        @(negedge clock);
        bus.startGame = 1'b0;
    endtask

    task automatic masterPulse();
        bus.masterLoaded = 1'b1;
        @(negedge clock);
        bus.masterLoaded = 1'b0;
    endtask

    // One gradeIt pulse; the expected capture is queued now and checked when doneGrading fires.
    task automatic grade(input logic [3:0] zn, input logic [3:0] zd, input logic gw);
        exp_t e;
        int   n;
        bus.ZnarlyCount = zn;
        bus.ZoodCount   = zd;
        bus.GameWon     = gw;
        bus.gradeIt     = 1'b1;
        expRounds++;
        e.zn = zn;
        e.zd = zd;
        e.rounds = 4'(expRounds);
        sbQ.push_back(e);
        @(negedge clock);
        bus.gradeIt = 1'b0;
        n = 1;
        while (bus.doneGrading !== 1'b1 && n < 5) begin
            @(negedge clock);
            n++;
        end
        check("gradeLatency", n, 2);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check("lastZnarly", bus.lastZnarly, e.zn);
            check("lastZood", bus.lastZood, e.zd);
            check("roundsUsed", bus.roundsUsed, e.rounds);
        end
        @(negedge clock);
        check("donePulseWidth", bus.doneGrading, 0);
        bus.GameWon = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] zn;
        logic [3:0] zd;
        bus.startGame    = 1'b0;
        bus.masterLoaded = 1'b0;
        bus.gradeIt      = 1'b0;
        bus.ZnarlyCount  = 4'd0;
        bus.ZoodCount    = 4'd0;
        bus.GameWon      = 1'b0;

        // Reset and idle
        #1;
        check("resetOutputs", outVec(), 0);
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        check("idleOutputs", outVec(), 0);

        // Start and load
        startPulse();
        check("loadingShape", bus.loadingShape, 1);
        check("loadOngoing", bus.ongoingGame, 0);
        masterPulse();
        check("playOngoing", bus.ongoingGame, 1);
        check("playRoundsLeft", bus.areRoundsLeft, 1);
        check("playRounds0", bus.roundsUsed, 0);
        check("playLoading", bus.loadingShape, 0);

        // First grade, then a mid-game startGame that must be ignored
        grade(4'd2, 4'd2, 1'b0);
        check("backInPlay", bus.ongoingGame, 1);
        startPulse();
        check("restartIgnoredOngoing", bus.ongoingGame, 1);
        check("restartIgnoredLoading", bus.loadingShape, 0);
        check("restartIgnoredRounds", bus.roundsUsed, 1);

        // Seven more non-winning grades exhaust the game
        for (int i = 2; i <= 8; i++) begin
            zn = 4'(i % 4);
            zd = 4'((i + 1) % 4);
            grade(zn, zd, 1'b0);
        end
        check("lostFlag", bus.lost, 1);
        check("lostWon", bus.won, 0);
        check("lostOngoing", bus.ongoingGame, 0);
        check("lostRoundsLeft", bus.areRoundsLeft, 0);
        check("lostRounds", bus.roundsUsed, 8);

        // gradeIt after loss changes nothing
        bus.gradeIt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("lostGradeNoDone", bus.doneGrading, 0);
        end
        bus.gradeIt = 1'b0;
        check("lostGradeRounds", bus.roundsUsed, 8);
        check("lostGradeHold", bus.lost, 1);

        // New game from LOST clears results; win on the last allowed round
        startPulse();
        expRounds = 0;
        check("reloadLoading", bus.loadingShape, 1);
        check("reloadRounds", bus.roundsUsed, 0);
        check("reloadZnarly", bus.lastZnarly, 0);
        check("reloadZood", bus.lastZood, 0);
        check("reloadLost", bus.lost, 0);
        masterPulse();
        for (int i = 1; i <= 7; i++) begin
            zn = 4'(i % 3);
            zd = 4'(i % 4);
            grade(zn, zd, 1'b0);
        end
        grade(4'd4, 4'd0, 1'b1);
        check("lastRoundWon", bus.won, 1);
        check("lastRoundLost", bus.lost, 0);
        check("lastRoundGames", bus.gamesWon, 1);
        check("lastRoundRounds", bus.roundsUsed, 8);

        // Fifteen more wins push gamesWon into saturation
        for (int k = 2; k <= 16; k++) begin
            startPulse();
            expRounds = 0;
            masterPulse();
            grade(4'd4, 4'd0, 1'b1);
            check("gamesWonCount", bus.gamesWon, (k > 15) ? 15 : k);
        end
        startPulse();
        expRounds = 0;
        check("wonToLoad", bus.loadingShape, 1);
        check("wonToLoadRounds", bus.roundsUsed, 0);
        check("wonToLoadZnarly", bus.lastZnarly, 0);
        check("wonToLoadWon", bus.won, 0);
        check("gamesWonHold", bus.gamesWon, 15);

        // Reset asserted mid-cycle while in GRADE
        masterPulse();
        bus.ZnarlyCount = 4'd3;
        bus.ZoodCount   = 4'd1;
        bus.gradeIt     = 1'b1;
        @(posedge clock);
        #2;
        reset_L = 1'b0;
        #1;
        check("resetInGrade", outVec(), 0);
        bus.gradeIt = 1'b0;
        @(negedge clock);
        check("resetNoDone", bus.doneGrading, 0);
        check("resetHeld", outVec(), 0);
        reset_L = 1'b1;
        @(negedge clock);
        check("idleAfterReset", outVec(), 0);
        startPulse();
        check("idleToLoad", bus.loadingShape, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
